// File: rtl/reflet_irq_latch.sv
// Interrupt front-end for reflet_cpu: synchronises four IRQ lines, latches edge/level
// requests and exposes pending/mask/mode/raw status as four memory-mapped registers.
module reflet_irq_latch #(
  parameter int unsigned wordsize   = 16,
  parameter int unsigned base_addr  = 'hF0,
  parameter logic [3:0]  mask_reset = 4'hF,
  parameter logic [3:0]  mode_reset = 4'hF
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                enable,
  input  logic [3:0]          irq_in,
  input  logic [wordsize-1:0] addr,
  input  logic [wordsize-1:0] data_in,
  input  logic                write_en,
  output logic [wordsize-1:0] data_out,
  output logic [3:0]          ext_int
);

  localparam int unsigned nlines = 4;
  localparam logic [wordsize-1:0] base_w = wordsize'(base_addr);
  localparam logic [wordsize-1:0] last_w = wordsize'(base_addr + 3);

  logic [nlines-1:0]   s1_q, s2_q, prev_q;
  logic [nlines-1:0]   pending_q, pending_d;
  logic [nlines-1:0]   mask_q, mask_d;
  logic [nlines-1:0]   mode_q, mode_d;
  logic [nlines-1:0]   ext_int_q, ext_int_d;
  logic [wordsize-1:0] data_out_q, data_out_d;

  logic                sel_c, wr_c;
  logic [1:0]          offset_c;
  logic [nlines-1:0]   rise_c, clr_c, rd_c;
  logic                unused_data_hi;

  assign unused_data_hi = ^data_in[wordsize-1:nlines];

  // Address decode at full bus width; offset is only meaningful while selected.
  assign sel_c    = (addr >= base_w) && (addr <= last_w);
  assign offset_c = 2'(addr - base_w);
  assign wr_c     = enable & write_en & sel_c;
  assign rise_c   = s2_q & ~prev_q;
  assign clr_c    = (wr_c && (offset_c == 2'd0)) ? data_in[nlines-1:0] : '0;

  always_comb begin
    rd_c = '0;
    case (offset_c)
      2'd0:    rd_c = pending_q;
      2'd1:    rd_c = mask_q;
      2'd2:    rd_c = mode_q;
      default: rd_c = s2_q;
    endcase
  end

  // Edge lines: set beats W1C clear. Level lines track the synchronised input.
  always_comb begin
    pending_d  = pending_q;
    mask_d     = mask_q;
    mode_d     = mode_q;
    data_out_d = data_out_q;
    for (int i = 0; i < int'(nlines); i++) begin
      if (mode_q[i]) begin
        pending_d[i] = rise_c[i] | (pending_q[i] & ~clr_c[i]);
      end else begin
        pending_d[i] = s2_q[i];
      end
    end
    if (wr_c && (offset_c == 2'd1)) begin
      mask_d = data_in[nlines-1:0];
    end
    if (wr_c && (offset_c == 2'd2)) begin
      mode_d = data_in[nlines-1:0];
    end
    if (enable) begin
      data_out_d = (sel_c && !write_en) ? wordsize'(rd_c) : '0;
    end
    ext_int_d = pending_d & mask_d;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      s1_q       <= '0;
      s2_q       <= '0;
      prev_q     <= '0;
      pending_q  <= '0;
      mask_q     <= mask_reset;
      mode_q     <= mode_reset;
      ext_int_q  <= '0;
      data_out_q <= '0;
    end else begin
      s1_q       <= irq_in;
      s2_q       <= s1_q;
      prev_q     <= s2_q;
      pending_q  <= pending_d;
      mask_q     <= mask_d;
      mode_q     <= mode_d;
      ext_int_q  <= ext_int_d;
      data_out_q <= data_out_d;
    end
  end

  assign data_out = data_out_q;
  assign ext_int  = ext_int_q;

endmodule
